// File: rtl/adf4351_pkg.sv
// ============================================================================
// Module : adf4351_pkg
// Brief  : Shared constants, field offsets and LD state type for the ADF4351
//          serial sink.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package adf4351_pkg;

  localparam int ADF_WORD_W = 32;

  localparam logic [2:0] ADF_R0 = 3'd0;
  localparam logic [2:0] ADF_R1 = 3'd1;
  localparam logic [2:0] ADF_R2 = 3'd2;
  localparam logic [2:0] ADF_R3 = 3'd3;
  localparam logic [2:0] ADF_R4 = 3'd4;
  localparam logic [2:0] ADF_R5 = 3'd5;

  localparam int ADF_NUM_REGS = 6;

  localparam int ADF_INT_LSB       = 15;
  localparam int ADF_INT_W         = 16;
  localparam int ADF_FRAC_LSB      = 3;
  localparam int ADF_FRAC_W        = 12;
  localparam int ADF_MOD_LSB       = 3;
  localparam int ADF_MOD_W         = 12;
  localparam int ADF_R2_PD_BIT     = 5;
  localparam int ADF_R4_DIVSEL_LSB = 20;
  localparam int ADF_R4_DIVSEL_W   = 3;

  localparam int         ADF_BITCNT_W   = 6;
  localparam logic [5:0] ADF_BITCNT_MAX = 6'd63;

  typedef enum logic [1:0] {
    LD_PD   = 2'd0,
    LD_WAIT = 2'd1,
    LD_LOCK = 2'd2
  } ld_state_t;

  // Control bits 6 and 7 do not map to a real register.
  function automatic logic adf_addr_ok(input logic [2:0] addr);
    return (addr <= ADF_R5);
  endfunction

endpackage

`default_nettype wire

// File: rtl/adf4351_shift_rx.sv
// ============================================================================
// Module : adf4351_shift_rx
// Brief  : Serial front end: MSB-first shift register, saturating bit counter
//          and LE rise detection producing a latch strobe with address.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module adf4351_shift_rx
  import adf4351_pkg::*;
#(
  parameter int MIN_BITS = 32
) (
  input  logic                  clk_div,
  input  logic                  rst_n,
  input  logic                  i_ser_data,
  input  logic                  i_ser_le,
  output logic [ADF_WORD_W-1:0] o_word,
  output logic [2:0]            o_addr,
  output logic                  o_latch,
  output logic                  o_full
);

  localparam logic [ADF_BITCNT_W:0] c_MIN_BITS = (ADF_BITCNT_W+1)'(MIN_BITS);

  logic [ADF_WORD_W-1:0]   r_sr;
  logic [ADF_BITCNT_W-1:0] r_bitcnt;
  logic                    r_le_q;

  always_ff @(posedge clk_div or negedge rst_n) begin
    if (!rst_n) begin
      r_sr     <= '0;
      r_bitcnt <= '0;
      r_le_q   <= 1'b0;
    end else begin
      r_le_q <= i_ser_le;
      if (!i_ser_le) begin
        r_sr <= {r_sr[ADF_WORD_W-2:0], i_ser_data};
        if (r_bitcnt != ADF_BITCNT_MAX) begin
          r_bitcnt <= r_bitcnt + 6'd1;
        end
      end else if (!r_le_q) begin
        r_bitcnt <= '0;
      end
    end
  end

  // The strobe is combinational so the bank updates on the very edge that
  // first samples LE high, while sr still holds the completed word.
  assign o_latch = i_ser_le & ~r_le_q;
  assign o_word  = r_sr;
  assign o_addr  = r_sr[2:0];
  assign o_full  = ({1'b0, r_bitcnt} >= c_MIN_BITS);

endmodule

`default_nettype wire

// File: rtl/adf4351_serial_sink.sv
// ============================================================================
// Module : adf4351_serial_sink
// Brief  : ADF4351 3-wire receive end: register bank R0..R5, frame error
//          accounting and lock-detect emulation. Defining
//          ADF4351_SINK_DECODE_EN adds registered INT/FRAC/MOD/divider fields.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module adf4351_serial_sink
  import adf4351_pkg::*;
#(
  parameter int LD_DELAY = 16,
  parameter int MIN_BITS = 32
) (
  input  logic                  clk_div,
  input  logic                  rst_n,
  input  logic                  i_ser_data,
  input  logic                  i_ser_le,
  input  logic                  i_ser_ce,
  output logic                  o_ld,
  output logic [ADF_WORD_W-1:0] o_r0,
  output logic [ADF_WORD_W-1:0] o_r1,
  output logic [ADF_WORD_W-1:0] o_r2,
  output logic [ADF_WORD_W-1:0] o_r3,
  output logic [ADF_WORD_W-1:0] o_r4,
  output logic [ADF_WORD_W-1:0] o_r5,
  output logic                  o_wr_stb,
  output logic [2:0]            o_wr_idx,
  output logic [5:0]            o_reg_valid,
  output logic                  o_frame_err,
  output logic [7:0]            o_err_cnt
`ifdef ADF4351_SINK_DECODE_EN
  ,
  output logic [15:0]           o_int_val,
  output logic [11:0]           o_frac_val,
  output logic [11:0]           o_mod_val,
  output logic [2:0]            o_rf_div_sel
`endif
);

  localparam logic [7:0] c_LD_DELAY = 8'(LD_DELAY);

  logic [ADF_WORD_W-1:0] w_word;
  logic [2:0]            w_addr;
  logic                  w_latch;
  logic                  w_full;
  logic                  w_accept;
  logic                  w_reject;
  logic                  w_r0_wr;
  logic                  w_pd;

  logic [ADF_WORD_W-1:0] r_regs [ADF_NUM_REGS];
  logic [5:0]            r_valid;
  logic                  r_wr_stb;
  logic [2:0]            r_wr_idx;
  logic                  r_frame_err;
  logic [7:0]            r_err_cnt;
  ld_state_t             r_ld_state;
  logic [7:0]            r_ld_cnt;
  logic                  r_ld;

  adf4351_shift_rx #(
    .MIN_BITS (MIN_BITS)
  ) u_shift_rx (
    .clk_div    (clk_div),
    .rst_n      (rst_n),
    .i_ser_data (i_ser_data),
    .i_ser_le   (i_ser_le),
    .o_word     (w_word),
    .o_addr     (w_addr),
    .o_latch    (w_latch),
    .o_full     (w_full)
  );

  assign w_accept = w_latch & w_full & adf_addr_ok(w_addr);
  assign w_reject = w_latch & ~(w_full & adf_addr_ok(w_addr));
  assign w_r0_wr  = w_accept & (w_addr == ADF_R0);
  assign w_pd     = ~i_ser_ce | r_regs[2][ADF_R2_PD_BIT];

  always_ff @(posedge clk_div or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ADF_NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
      r_valid     <= '0;
      r_wr_stb    <= 1'b0;
      r_wr_idx    <= '0;
      r_frame_err <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_wr_stb    <= w_accept;
      r_frame_err <= w_reject;
      if (w_accept) begin
        r_wr_idx <= w_addr;
        for (int i = 0; i < ADF_NUM_REGS; i++) begin
          if (w_addr == 3'(i)) begin
            r_regs[i]  <= w_word;
            r_valid[i] <= 1'b1;
          end
        end
      end
      if (w_reject && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  // Power-down dominates; an R0 write (re)arms the lock timer from any state.
  always_ff @(posedge clk_div or negedge rst_n) begin
    if (!rst_n) begin
      r_ld_state <= LD_PD;
      r_ld_cnt   <= '0;
      r_ld       <= 1'b0;
    end else if (w_pd) begin
      r_ld_state <= LD_PD;
      r_ld       <= 1'b0;
    end else if (w_r0_wr) begin
      r_ld_state <= LD_WAIT;
      r_ld_cnt   <= c_LD_DELAY;
      r_ld       <= 1'b0;
    end else begin
      case (r_ld_state)
        LD_PD: begin
          r_ld <= 1'b0;
          if (r_valid[0]) begin
            r_ld_state <= LD_WAIT;
            r_ld_cnt   <= c_LD_DELAY;
          end
        end
        LD_WAIT: begin
          if (r_ld_cnt <= 8'd1) begin
            r_ld_state <= LD_LOCK;
            r_ld_cnt   <= '0;
            r_ld       <= 1'b1;
          end else begin
            r_ld_cnt <= r_ld_cnt - 8'd1;
          end
        end
        LD_LOCK: begin
          r_ld <= 1'b1;
        end
        default: begin
          r_ld_state <= LD_PD;
          r_ld       <= 1'b0;
        end
      endcase
    end
  end

`ifdef ADF4351_SINK_DECODE_EN
  always_ff @(posedge clk_div or negedge rst_n) begin
    if (!rst_n) begin
      o_int_val    <= '0;
      o_frac_val   <= '0;
      o_mod_val    <= '0;
      o_rf_div_sel <= '0;
    end else begin
      o_int_val    <= r_regs[0][ADF_INT_LSB +: ADF_INT_W];
      o_frac_val   <= r_regs[0][ADF_FRAC_LSB +: ADF_FRAC_W];
      o_mod_val    <= r_regs[1][ADF_MOD_LSB +: ADF_MOD_W];
      o_rf_div_sel <= r_regs[4][ADF_R4_DIVSEL_LSB +: ADF_R4_DIVSEL_W];
    end
  end
`endif

  assign o_r0        = r_regs[0];
  assign o_r1        = r_regs[1];
  assign o_r2        = r_regs[2];
  assign o_r3        = r_regs[3];
  assign o_r4        = r_regs[4];
  assign o_r5        = r_regs[5];
  assign o_reg_valid = r_valid;
  assign o_wr_stb    = r_wr_stb;
  assign o_wr_idx    = r_wr_idx;
  assign o_frame_err = r_frame_err;
  assign o_err_cnt   = r_err_cnt;
  assign o_ld        = r_ld;

endmodule

`default_nettype wire

// File: tb/tb_adf4351_serial_sink.sv
// ============================================================================
// Module : tb_adf4351_serial_sink
// Brief  : Self-checking bench for adf4351_serial_sink against a bit-history
//          reference model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_adf4351_serial_sink;

  localparam int LD_DELAY = 16;

  logic        clk_div = 1'b0;
  logic        rst_n = 1'b0;
  logic        ser_data = 1'b0;
  logic        ser_le = 1'b0;
  logic        ser_ce = 1'b1;
  logic        ld;
  logic [31:0] r0, r1, r2, r3, r4, r5;
  logic        wr_stb;
  logic [2:0]  wr_idx;
  logic [5:0]  reg_valid;
  logic        frame_err;
  logic [7:0]  err_cnt;
`ifdef ADF4351_SINK_DECODE_EN
  logic [15:0] int_val;
  logic [11:0] frac_val;
  logic [11:0] mod_val;
  logic [2:0]  rf_div_sel;
`endif

  adf4351_serial_sink #(
    .LD_DELAY (LD_DELAY),
    .MIN_BITS (32)
  ) dut (
    .clk_div     (clk_div),
    .rst_n       (rst_n),
    .i_ser_data  (ser_data),
    .i_ser_le    (ser_le),
    .i_ser_ce    (ser_ce),
    .o_ld        (ld),
    .o_r0        (r0),
    .o_r1        (r1),
    .o_r2        (r2),
    .o_r3        (r3),
    .o_r4        (r4),
    .o_r5        (r5),
    .o_wr_stb    (wr_stb),
    .o_wr_idx    (wr_idx),
    .o_reg_valid (reg_valid),
    .o_frame_err (frame_err),
    .o_err_cnt   (err_cnt)
`ifdef ADF4351_SINK_DECODE_EN
    ,
    .o_int_val    (int_val),
    .o_frac_val   (frac_val),
    .o_mod_val    (mod_val),
    .o_rf_div_sel (rf_div_sel)
`endif
  );

  always #5 clk_div = ~clk_div;

  int checks = 0;
  int errors = 0;

  logic [31:0] dut_r [6];
  assign dut_r[0] = r0;
  assign dut_r[1] = r1;
  assign dut_r[2] = r2;
  assign dut_r[3] = r3;
  assign dut_r[4] = r4;
  assign dut_r[5] = r5;

  // Reference model: remembers the last 32 bits seen with LE low and how many
  // arrived since the previous LE rise; judges each frame from those alone.
  bit          m_hist[$];
  int          m_cnt;
  logic        m_le_q;
  logic [31:0] m_r [6];
  logic [5:0]  m_valid;
  logic [7:0]  m_errcnt;
  logic        m_stb;
  logic        m_err;
  logic [2:0]  m_idx;
  logic [31:0] m_word;
  int          m_addr;

  initial begin
    forever begin
      @(posedge clk_div or negedge rst_n);
      if (!rst_n) begin
        m_hist.delete();
        m_cnt = 0; m_le_q = 1'b0; m_valid = '0; m_errcnt = '0;
        m_stb = 1'b0; m_err = 1'b0; m_idx = '0;
        for (int i = 0; i < 6; i++) m_r[i] = '0;
      end else begin
        m_stb = 1'b0;
        m_err = 1'b0;
        if (ser_le && !m_le_q) begin
          m_word = '0;
          foreach (m_hist[i]) m_word = {m_word[30:0], m_hist[i]};
          m_addr = int'(m_word[2:0]);
          if (m_cnt >= 32 && m_addr < 6) begin
            m_r[m_addr] = m_word;
            m_valid[m_addr] = 1'b1;
            m_stb = 1'b1;
            m_idx = m_word[2:0];
          end else begin
            m_err = 1'b1;
            if (m_errcnt < 8'd255) m_errcnt = m_errcnt + 8'd1;
          end
          m_cnt = 0;
        end else if (!ser_le) begin
          m_hist.push_back(ser_data);
          if (m_hist.size() > 32) void'(m_hist.pop_front());
          m_cnt++;
        end
        m_le_q = ser_le;
      end
    end
  end

  task automatic shift_bits(input logic [31:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk_div);
      ser_le   = 1'b0;
      ser_data = w[i];
    end
  endtask

  task automatic raise_le();
    @(negedge clk_div);
    ser_le = 1'b1;
    @(posedge clk_div);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk_div);
    #1;
    checks++; if (ld !== 1'b0) begin errors++; $display("FAIL reset_ld got %b exp 0", ld); end
    checks++; if (wr_stb !== 1'b0) begin errors++; $display("FAIL reset_wr_stb got %b exp 0", wr_stb); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b exp 0", frame_err); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err_cnt got %0d exp 0", err_cnt); end
    checks++; if (reg_valid !== 6'd0) begin errors++; $display("FAIL reset_reg_valid got %b exp 0", reg_valid); end
    checks++; if (wr_idx !== 3'd0) begin errors++; $display("FAIL reset_wr_idx got %0d exp 0", wr_idx); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (dut_r[i] !== 32'd0) begin errors++; $display("FAIL reset_r%0d got %h exp 0", i, dut_r[i]); end
    end
    @(negedge clk_div);
    rst_n = 1'b1;
  endtask

  task automatic test_single_frame();
    shift_bits(32'h00580005, 32);
    raise_le();
    checks++; if (wr_stb !== 1'b1) begin errors++; $display("FAIL single_stb got %b exp 1", wr_stb); end
    checks++; if (wr_idx !== 3'd5) begin errors++; $display("FAIL single_idx got %0d exp 5", wr_idx); end
    checks++; if (r5 !== 32'h00580005) begin errors++; $display("FAIL single_r5 got %h exp 00580005", r5); end
    checks++; if (reg_valid !== 6'b100000) begin errors++; $display("FAIL single_valid got %b exp 100000", reg_valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL single_err got %b exp 0", frame_err); end
    // LE held high: no further strobes
    for (int k = 0; k < 3; k++) begin
      @(posedge clk_div); #1;
      checks++; if (wr_stb !== 1'b0) begin errors++; $display("FAIL single_hold_stb cyc %0d got %b exp 0", k, wr_stb); end
    end
  endtask

  task automatic test_sequence();
    logic [31:0] words [6];
    words = '{32'h00580005, 32'h00DC803C, 32'h000004B3, 32'h01004E42, 32'h08008011, 32'h00400000};
    for (int j = 0; j < 6; j++) begin
      shift_bits(words[j], 32);
      raise_le();
      checks++; if (wr_stb !== 1'b1 || wr_idx !== 3'(5 - j)) begin
        errors++; $display("FAIL seq_stb_idx word %0d got stb %b idx %0d exp stb 1 idx %0d", j, wr_stb, wr_idx, 5 - j);
      end
    end
    checks++; if (ld !== 1'b0) begin errors++; $display("FAIL seq_ld_at_latch got %b exp 0", ld); end
    for (int k = 1; k <= LD_DELAY + 2; k++) begin
      @(posedge clk_div); #1;
      checks++; if (ld !== (k >= LD_DELAY)) begin
        errors++; $display("FAIL seq_ld_delay cyc %0d got %b exp %b", k, ld, (k >= LD_DELAY));
      end
    end
    for (int i = 0; i < 6; i++) begin
      checks++; if (dut_r[i] !== words[5 - i]) begin errors++; $display("FAIL seq_r%0d got %h exp %h", i, dut_r[i], words[5 - i]); end
    end
    checks++; if (reg_valid !== 6'h3F) begin errors++; $display("FAIL seq_valid got %h exp 3f", reg_valid); end
  endtask

  task automatic test_errors();
    shift_bits(32'h000ABCDE, 20);
    raise_le();
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL short_err got %b exp 1", frame_err); end
    checks++; if (wr_stb !== 1'b0) begin errors++; $display("FAIL short_stb got %b exp 0", wr_stb); end
    checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL short_err_cnt got %0d exp 1", err_cnt); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (dut_r[i] !== m_r[i]) begin errors++; $display("FAIL short_r%0d got %h exp %h", i, dut_r[i], m_r[i]); end
    end
    @(posedge clk_div); #1;
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL short_err_pulse got %b exp 0", frame_err); end
    shift_bits(32'h00000006, 32);
    raise_le();
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL addr6_err got %b exp 1", frame_err); end
    checks++; if (err_cnt !== 8'd2) begin errors++; $display("FAIL addr6_err_cnt got %0d exp 2", err_cnt); end
    checks++; if (wr_stb !== 1'b0) begin errors++; $display("FAIL addr6_stb got %b exp 0", wr_stb); end
  endtask

  task automatic test_power_down();
    checks++; if (ld !== 1'b1) begin errors++; $display("FAIL pd_ld_before got %b exp 1", ld); end
    @(negedge clk_div);
    ser_ce = 1'b0;
    @(posedge clk_div); #1;
    checks++; if (ld !== 1'b0) begin errors++; $display("FAIL pd_ce_drop got %b exp 0", ld); end
    @(negedge clk_div);
    ser_ce = 1'b1;
    shift_bits(32'h00000020 | 32'h2, 32);
    raise_le();
    checks++; if (r2 !== 32'h00000022) begin errors++; $display("FAIL pd_r2 got %h exp 00000022", r2); end
    shift_bits(32'h00400000, 32);
    raise_le();
    for (int k = 0; k < LD_DELAY + 4; k++) begin
      @(posedge clk_div); #1;
      checks++; if (ld !== 1'b0) begin errors++; $display("FAIL pd_r2_ld cyc %0d got %b exp 0", k, ld); end
    end
    shift_bits(32'h01004E42, 32);
    raise_le();
    shift_bits(32'h00400000, 32);
    checks++; if (ld !== 1'b1) begin errors++; $display("FAIL pd_relock got %b exp 1", ld); end
    @(negedge clk_div);
    ser_le = 1'b1;
    ser_ce = 1'b0;
    @(posedge clk_div); #1;
    checks++; if (wr_stb !== 1'b1) begin errors++; $display("FAIL pd_simul_stb got %b exp 1", wr_stb); end
    for (int k = 0; k < LD_DELAY + 3; k++) begin
      checks++; if (ld !== 1'b0) begin errors++; $display("FAIL pd_simul_ld cyc %0d got %b exp 0", k, ld); end
      @(posedge clk_div); #1;
    end
    @(negedge clk_div);
    ser_ce = 1'b1;
  endtask

  task automatic test_reset_midframe();
    shift_bits(32'h000004B3 >> 16, 16);
    @(negedge clk_div);
    rst_n = 1'b0;
    @(posedge clk_div); #1;
    checks++; if (reg_valid !== 6'd0 || err_cnt !== 8'd0 || ld !== 1'b0 || wr_stb !== 1'b0 || frame_err !== 1'b0 || wr_idx !== 3'd0) begin
      errors++; $display("FAIL rstmid_ctrl got valid %h cnt %0d ld %b stb %b err %b idx %0d exp all 0", reg_valid, err_cnt, ld, wr_stb, frame_err, wr_idx);
    end
    checks++; if ({r0, r1, r2, r3, r4, r5} !== 192'd0) begin errors++; $display("FAIL rstmid_regs got nonzero r0 %h r3 %h exp 0", r0, r3); end
    @(negedge clk_div);
    rst_n = 1'b1;
    shift_bits(32'h000004B3, 32);
    raise_le();
    checks++; if (wr_stb !== 1'b1 || wr_idx !== 3'd3) begin errors++; $display("FAIL rstmid_stb got stb %b idx %0d exp 1 3", wr_stb, wr_idx); end
    checks++; if (r3 !== 32'h000004B3) begin errors++; $display("FAIL rstmid_r3 got %h exp 000004b3", r3); end
    checks++; if (reg_valid !== 6'b001000) begin errors++; $display("FAIL rstmid_valid got %b exp 001000", reg_valid); end
  endtask

`ifdef ADF4351_SINK_DECODE_EN
  task automatic test_decode();
    shift_bits(32'h08008011, 32); raise_le();
    shift_bits(32'h00DC803C, 32); raise_le();
    shift_bits(32'h00400000, 32); raise_le();
    @(posedge clk_div); #1;
    checks++; if (int_val !== 16'd128) begin errors++; $display("FAIL dec_int got %0d exp 128", int_val); end
    checks++; if (frac_val !== 12'd0) begin errors++; $display("FAIL dec_frac got %0d exp 0", frac_val); end
    checks++; if (mod_val !== 12'd2) begin errors++; $display("FAIL dec_mod got %0d exp 2", mod_val); end
    checks++; if (rf_div_sel !== 3'd5) begin errors++; $display("FAIL dec_div got %0d exp 5", rf_div_sel); end
  endtask
`endif

  task automatic test_random();
    logic [31:0] w;
    int n;
    int extra;
    for (int it = 0; it < 40; it++) begin
      w = ($urandom() & 32'hFFFF_FFF8) | 32'($urandom_range(0, 7));
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(8, 31)) : 32;
      extra = int'($urandom_range(0, 2));
      shift_bits(w, n);
      for (int e = 0; e < extra; e++) begin
        @(negedge clk_div);
        ser_data = 1'($urandom_range(0, 1));
      end
      raise_le();
      checks++; if (wr_stb !== m_stb || frame_err !== m_err) begin
        errors++; $display("FAIL rnd_flags it %0d got stb %b err %b exp stb %b err %b", it, wr_stb, frame_err, m_stb, m_err);
      end
      checks++; if (wr_idx !== m_idx || reg_valid !== m_valid || err_cnt !== m_errcnt) begin
        errors++; $display("FAIL rnd_state it %0d got idx %0d valid %h cnt %0d exp idx %0d valid %h cnt %0d", it, wr_idx, reg_valid, err_cnt, m_idx, m_valid, m_errcnt);
      end
      for (int i = 0; i < 6; i++) begin
        checks++; if (dut_r[i] !== m_r[i]) begin errors++; $display("FAIL rnd_r%0d it %0d got %h exp %h", i, it, dut_r[i], m_r[i]); end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_frame();
    test_sequence();
    test_errors();
    test_power_down();
    test_reset_midframe();
`ifdef ADF4351_SINK_DECODE_EN
    test_decode();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
